// File: rtl/hack_mem_if.sv
// CPU-side memory bus of the Hack memory controller.
// Request channel:  req_valid/req_ready handshake carrying req_we, req_addr, req_wdata.
// Response channel: rsp_valid/rsp_ready handshake carrying rsp_rdata, rsp_err.
// The slave modport is the controller; the master modport is the CPU.
interface hack_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/hack_mem_ctrl.sv
// Hack memory-bus controller feeding the 4-way load demultiplexer.
// Accepts one CPU request at a time, decodes req_addr[14:13] into a bank
// select, emits a one-cycle bank_load strobe for non-errored writes, waits a
// per-bank number of cycles and returns read data / write acknowledge.
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   cpu            : request/response handshake (hack_mem_if.slave)
//   bank_sel       : demux select (00 RAM-lo, 01 RAM-hi, 10 screen, 11 keyboard)
//   bank_load      : demux data input, one-cycle write strobe
//   bank_addr      : offset within the selected bank
//   bank_wdata     : write data to the banks
//   bank_rdata     : muxed read data from the selected bank
module hack_mem_ctrl #(
  parameter int unsigned RAM_WAIT    = 1,
  parameter int unsigned SCREEN_WAIT = 2,
  parameter int unsigned KBD_WAIT    = 1
) (
  input  logic             clk,
  input  logic             reset,
  hack_mem_if.slave        cpu,
  output logic [1:0]       bank_sel,
  output logic             bank_load,
  output logic [12:0]      bank_addr,
  output logic [15:0]      bank_wdata,
  input  logic [15:0]      bank_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic        err_r;
  logic        accept_s;
  logic        sample_s;
  logic        dec_err_s;
  logic [3:0]  wait_s;

  // Address decode: wait-state count per bank and unmapped/read-only detection.
  always_comb begin
    wait_s    = 4'(RAM_WAIT);
    dec_err_s = 1'b0;
    case (cpu.req_addr[14:13])
      2'b10: begin
        wait_s    = 4'(SCREEN_WAIT);
        dec_err_s = 1'b0;
      end
      2'b11: begin
        wait_s    = 4'(KBD_WAIT);
        // Only 0x6000 exists, and it cannot be written.
        dec_err_s = (cpu.req_addr[12:0] != 13'd0) || cpu.req_we;
      end
      default: begin
        wait_s    = 4'(RAM_WAIT);
        dec_err_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; accept and sample strobes for the datapath.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    sample_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu.req_valid && cpu.req_ready) begin
          accept_s   = 1'b1;
          state_nx_s = ACCESS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS: begin
        // The counter starts at WAIT and the access ends on the cycle it
        // shows zero, giving WAIT+1 ACCESS cycles in total.
        if (cnt_r == 4'd0) begin
          sample_s   = 1'b1;
          state_nx_s = RESP;
        end else begin
          state_nx_s = ACCESS;
        end
      end
      RESP: begin
        if (cpu.rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register, latched request, wait counter and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      we_r          <= 1'b0;
      err_r         <= 1'b0;
      cpu.req_ready <= 1'b1;
      cpu.rsp_valid <= 1'b0;
      cpu.rsp_rdata <= 16'h0000;
      cpu.rsp_err   <= 1'b0;
      bank_sel      <= 2'b00;
      bank_load     <= 1'b0;
      bank_addr     <= 13'd0;
      bank_wdata    <= 16'h0000;
    end else begin
      state_r       <= state_nx_s;
      // Ready/valid follow the state being entered, so a request offered
      // while a response is accepted only sees ready one cycle later.
      cpu.req_ready <= (state_nx_s == IDLE);
      cpu.rsp_valid <= (state_nx_s == RESP);
      // High only in the first ACCESS cycle of a non-errored write.
      bank_load     <= accept_s && cpu.req_we && !dec_err_s;
      if (accept_s) begin
        we_r       <= cpu.req_we;
        err_r      <= dec_err_s;
        cnt_r      <= wait_s;
        bank_sel   <= cpu.req_addr[14:13];
        bank_addr  <= cpu.req_addr[12:0];
        bank_wdata <= cpu.req_wdata;
      end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (sample_s) begin
        cpu.rsp_rdata <= (!we_r && !err_r) ? bank_rdata : 16'h0000;
        cpu.rsp_err   <= err_r;
      end
    end
  end

endmodule

// File: tb/tb_hack_mem_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for hack_mem_ctrl with default wait states
// (RAM 1, screen 2, keyboard 1). Vector table drives single transactions;
// a scoreboard queue holds expected responses checked by a monitor.
module tb_hack_mem_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  bank_sel;
  logic        bank_load;
  logic [12:0] bank_addr;
  logic [15:0] bank_wdata;
  logic [15:0] bank_rdata;

  hack_mem_if bus ();

  hack_mem_ctrl #(
    .RAM_WAIT    (1),
    .SCREEN_WAIT (2),
    .KBD_WAIT    (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (bus),
    .bank_sel   (bank_sel),
    .bank_load  (bank_load),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;      // value the bank presents on the sample cycle
    logic [1:0]  sel;
    logic [12:0] baddr;
    logic        load;
    logic        err;
    logic [15:0] exp_rdata;
    int          lat;        // wait states of the selected bank
  } vec_t;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  int   total;
  int   bad;
  int   n_push;
  int   n_rsp;
  vec_t tbl[10];

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares each accepted response with the queue head.
  always @(negedge clk) begin
    #1;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      rsp_t e;
      n_rsp++;
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  // One transaction, starting and ending at a negedge. bp>0 holds rsp_ready
  // low for that many cycles of RESP.
  task automatic do_txn(input vec_t v, input int bp);
    int n;
    n = 0;
    bus.rsp_ready = (bp == 0);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bank_rdata    = 16'hDEAD;
    sb_q.push_back('{rdata: v.exp_rdata, err: v.err});
    n_push++;
    @(negedge clk);
    chk("busy_ready", 32'(bus.req_ready), 32'd0);
    if (v.we && !v.err) begin
      chk("bank_wdata", 32'(bank_wdata), 32'(v.wdata));
    end
    for (int k = 1; k <= v.lat + 1; k++) begin
      chk("bank_sel", 32'(bank_sel), 32'(v.sel));
      chk("bank_addr", 32'(bank_addr), 32'(v.baddr));
      chk("bank_load", 32'(bank_load), 32'((k == 1) && v.load));
      chk("early_rsp", 32'(bus.rsp_valid), 32'd0);
      bank_rdata = (k == v.lat + 1) ? v.rdata : (16'hDEAD ^ 16'(k));
      // Request inputs may wander while busy; the controller uses its copy.
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = 15'($urandom);
      bus.req_wdata = 16'($urandom);
      @(negedge clk);
    end
    bank_rdata = 16'h0BAD;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("resp_ready_low", 32'(bus.req_ready), 32'd0);
    // Offer a request while the response is in flight; it must not be taken.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 15'h0100;
    if (bp > 0) begin
      for (int c = 0; c < bp; c++) begin
        @(negedge clk);
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rdata", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
        chk("bp_err", 32'(bus.rsp_err), 32'(v.err));
        chk("bp_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_load", 32'(bank_load), 32'd0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("idle_load", 32'(bank_load), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    total  = 0;
    bad    = 0;
    n_push = 0;
    n_rsp  = 0;
    //        we    addr      wdata     rdata     sel    baddr     load  err   exp_rdata lat
    tbl[0] = '{1'b1, 15'h0005, 16'hBEEF, 16'h0BAD, 2'b00, 13'h0005, 1'b1, 1'b0, 16'h0000, 1};
    tbl[1] = '{1'b0, 15'h4010, 16'h0000, 16'h1234, 2'b10, 13'h0010, 1'b0, 1'b0, 16'h1234, 2};
    tbl[2] = '{1'b0, 15'h6000, 16'h0000, 16'h0041, 2'b11, 13'h0000, 1'b0, 1'b0, 16'h0041, 1};
    tbl[3] = '{1'b1, 15'h6000, 16'h5555, 16'h0041, 2'b11, 13'h0000, 1'b0, 1'b1, 16'h0000, 1};
    tbl[4] = '{1'b0, 15'h6001, 16'h0000, 16'h7777, 2'b11, 13'h0001, 1'b0, 1'b1, 16'h0000, 1};
    tbl[5] = '{1'b1, 15'h1FFF, 16'h1111, 16'h0BAD, 2'b00, 13'h1FFF, 1'b1, 1'b0, 16'h0000, 1};
    tbl[6] = '{1'b1, 15'h2000, 16'h2222, 16'h0BAD, 2'b01, 13'h0000, 1'b1, 1'b0, 16'h0000, 1};
    tbl[7] = '{1'b1, 15'h5FFF, 16'h3333, 16'h0BAD, 2'b10, 13'h1FFF, 1'b1, 1'b0, 16'h0000, 2};
    tbl[8] = '{1'b1, 15'h7FFF, 16'h4444, 16'h0BAD, 2'b11, 13'h1FFF, 1'b0, 1'b1, 16'h0000, 1};
    tbl[9] = '{1'b0, 15'h2ABC, 16'h0000, 16'hCAFE, 2'b01, 13'h0ABC, 1'b0, 1'b0, 16'hCAFE, 1};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 15'h0000;
    bus.req_wdata = 16'h0000;
    bus.rsp_ready = 1'b1;
    bank_rdata    = 16'h0000;
    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_bank_load", 32'(bank_load), 32'd0);
    #9;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i], 0);
    end

    // Back-pressure on a screen read, then an immediate follow-up request.
    do_txn(tbl[1], 10);
    do_txn(tbl[9], 0);

    // Asynchronous reset during a screen write's wait count.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 15'h4020;
    bus.req_wdata = 16'hA5A5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("pre_reset_load", 32'(bank_load), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("mid_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("mid_bank_sel", 32'(bank_sel), 32'd0);
    chk("mid_bank_load", 32'(bank_load), 32'd0);
    chk("mid_bank_addr", 32'(bank_addr), 32'd0);
    chk("mid_bank_wdata", 32'(bank_wdata), 32'd0);
    #4;
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
    end

    // Recovery after reset.
    do_txn(tbl[0], 0);
    do_txn(tbl[2], 0);

    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("rsp_count", 32'(n_rsp), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
